// File: rtl/lgca_cell_pkg.sv
// Shared lattice-gas definitions: direction indices, opposite/rotate helpers,
// maximal-length LFSR tap table and the FHP symmetric-triple patterns.
package lgca_cell_pkg;

   localparam int HPP_E = 0;
   localparam int HPP_N = 1;
   localparam int HPP_W = 2;
   localparam int HPP_S = 3;

   localparam int FHP_D000 = 0;
   localparam int FHP_D060 = 1;
   localparam int FHP_D120 = 2;
   localparam int FHP_D180 = 3;
   localparam int FHP_D240 = 4;
   localparam int FHP_D300 = 5;

   localparam logic [5:0] FHP_TRIPLE_A = 6'b010101;
   localparam logic [5:0] FHP_TRIPLE_B = 6'b101010;

   function automatic int opp(input int d, input int dirs);
      return (d + dirs / 2) % dirs;
   endfunction

   function automatic int rot(input int d, input int dirs, input logic ccw);
      return ccw ? (d + 1) % dirs : (d + dirs - 1) % dirs;
   endfunction

   // Fibonacci feedback masks, bit (t-1) set for polynomial tap t
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/lgca_rng.sv
// Fibonacci LFSR with advance enable; a zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lgca_rng
   import lgca_cell_pkg::*;
#(
   parameter int          RNG_W = 16,
   parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
   input  logic clk,
   input  logic reset,
   input  logic adv,
   output logic msb
);

   if (RNG_W < 8 || RNG_W > 32) begin : g_bad_width
      $error("lgca_rng: RNG_W must be in 8..32");
   end

   localparam logic [RNG_W-1:0] SEED_W = SEED[RNG_W-1:0];
   localparam logic [RNG_W-1:0] INIT   = (SEED_W == '0) ? RNG_W'(1) : SEED_W;
   localparam logic [RNG_W-1:0] TAPS   = RNG_W'(lfsr_taps(RNG_W));

   logic [RNG_W-1:0] lfsr;
   logic             fb;

   assign fb  = ^(lfsr & TAPS);
   assign msb = lfsr[RNG_W-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= INIT;
      end else if (adv) begin
         lfsr <= {lfsr[RNG_W-2:0], fb};
      end
   end

endmodule

// File: rtl/lgca_cell.sv
// One lattice-gas automaton site (HPP square or FHP hex): streaming from the
// neighbours, collision / bounce-back rules, state load and collision statistics.
module lgca_cell
   import lgca_cell_pkg::*;
#(
   parameter int          DIRS    = 4,
   parameter int          RNG_W   = 16,
   parameter logic [31:0] SEED    = 32'h0000_ACE1,
   parameter int          COUNT_W = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DIRS*DIRS-1:0]         nbr_state,
   input  logic                         step_en,
   input  logic                         collide_en,
   input  logic                         wall,
   input  logic                         load,
   input  logic [DIRS-1:0]              load_state,
   output logic [DIRS-1:0]              state,
   output logic [$clog2(DIRS+1)-1:0]    particle_cnt,
   output logic [COUNT_W-1:0]           collision_cnt,
   output logic                         rnd_bit
);

   localparam int PCW = $clog2(DIRS + 1);

   if (DIRS != 4 && DIRS != 6) begin : g_bad_dirs
      $error("lgca_cell: DIRS must be 4 or 6");
   end

   logic [DIRS-1:0] inc;
   logic [DIRS-1:0] rev;
   logic [DIRS-1:0] nxt;
   logic [5:0]      inc6;
   logic            hit;
   logic            adv;

   function automatic logic [DIRS-1:0] pair_mask(input int d);
      return (DIRS'(1) << d) | (DIRS'(1) << opp(d, DIRS));
   endfunction

   // A particle moving d arrives from the neighbour lying in direction opp(d)
   for (genvar d = 0; d < DIRS; d++) begin : g_lane
      assign inc[d] = nbr_state[opp(d, DIRS)*DIRS + d];
      assign rev[d] = inc[opp(d, DIRS)];
   end

   assign inc6 = 6'(inc);

   always_comb begin
      nxt = inc;
      hit = 1'b0;
      if (wall) begin
         nxt = rev;
      end else if (collide_en) begin
         for (int d = 0; d < DIRS / 2; d++) begin
            if (inc == pair_mask(d)) begin
               nxt = pair_mask(rot(d, DIRS, rnd_bit));
               hit = 1'b1;
            end
         end
         if (DIRS == 6 && (inc6 == FHP_TRIPLE_A || inc6 == FHP_TRIPLE_B)) begin
            nxt = ~inc;
            hit = 1'b1;
         end
      end
   end

   assign adv = step_en & ~load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= '0;
         collision_cnt <= '0;
      end else if (load) begin
         state <= load_state;
      end else if (step_en) begin
         state <= nxt;
         if (hit && collision_cnt != '1) begin
            collision_cnt <= collision_cnt + COUNT_W'(1);
         end
      end
   end

   always_comb begin
      particle_cnt = '0;
      for (int d = 0; d < DIRS; d++) begin
         particle_cnt = particle_cnt + PCW'(state[d]);
      end
   end

   lgca_rng #(
      .RNG_W (RNG_W),
      .SEED  (SEED)
   ) u_rng (
      .clk   (clk),
      .reset (reset),
      .adv   (adv),
      .msb   (rnd_bit)
   );

endmodule

// File: tb/tb_lgca_cell.sv
// Directed bench for lgca_cell: one HPP site (4-bit counter) and one FHP site.
module tb_lgca_cell;

   logic        clk = 1'b0;
   logic        reset;

   logic [15:0] n4;
   logic        step4, col4, wall4, load4;
   logic [3:0]  ls4;
   logic [3:0]  st4;
   logic [2:0]  pc4;
   logic [3:0]  cc4;
   logic        rb4;

   logic [35:0] n6;
   logic        step6, col6, wall6, load6;
   logic [5:0]  ls6;
   logic [5:0]  st6;
   logic [2:0]  pc6;
   logic [7:0]  cc6;
   logic        rb6;

   logic [15:0] m4;
   logic [15:0] m6;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   lgca_cell #(.DIRS(4), .COUNT_W(4)) u4 (
      .clk(clk), .reset(reset), .nbr_state(n4), .step_en(step4), .collide_en(col4),
      .wall(wall4), .load(load4), .load_state(ls4), .state(st4),
      .particle_cnt(pc4), .collision_cnt(cc4), .rnd_bit(rb4)
   );

   lgca_cell #(.DIRS(6)) u6 (
      .clk(clk), .reset(reset), .nbr_state(n6), .step_en(step6), .collide_en(col6),
      .wall(wall6), .load(load6), .load_state(ls6), .state(st6),
      .particle_cnt(pc6), .collision_cnt(cc6), .rnd_bit(rb6)
   );

   // x^16 + x^15 + x^13 + x^4 + 1, shifting toward the MSB
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
   endfunction

   task automatic test_reset();
      @(negedge clk);
      n4 = 16'h0104; col4 = 1'b1; step4 = 1'b1;
      repeat (5) begin
         @(negedge clk);
         m4 = lfsr_next(m4);
      end
      step4 = 1'b0;
      total++;
      if (st4 !== 4'b1010) begin bad++; $display("FAIL pre_reset_state: got %b want %b", st4, 4'b1010); end
      total++;
      if (cc4 !== 4'd5) begin bad++; $display("FAIL pre_reset_cnt: got %0d want 5", cc4); end
      #2 reset = 1'b1;
      #1;
      m4 = 16'hACE1;
      m6 = 16'hACE1;
      total++;
      if (st4 !== 4'b0000) begin bad++; $display("FAIL reset_state: got %b want 0000", st4); end
      total++;
      if (cc4 !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cc4); end
      total++;
      if (pc4 !== 3'd0) begin bad++; $display("FAIL reset_pcnt: got %0d want 0", pc4); end
      total++;
      if (u4.u_rng.lfsr !== 16'hACE1) begin bad++; $display("FAIL reset_lfsr: got %h want ace1", u4.u_rng.lfsr); end
      total++;
      if (rb4 !== 1'b1) begin bad++; $display("FAIL reset_rnd: got %b want 1", rb4); end
      total++;
      if (st6 !== 6'b0 || cc6 !== 8'd0) begin bad++; $display("FAIL reset_fhp: got %b/%0d want 000000/0", st6, cc6); end
      @(negedge clk);
      reset = 1'b0;
      n4 = '0; col4 = 1'b0;
   endtask

   task automatic test_stream();
      @(negedge clk);
      n4 = 16'h0100; step4 = 1'b1; col4 = 1'b1;
      @(posedge clk); #1;
      m4 = lfsr_next(m4);
      total++;
      if (st4 !== 4'b0001) begin bad++; $display("FAIL stream_state: got %b want 0001", st4); end
      total++;
      if (pc4 !== 3'd1) begin bad++; $display("FAIL stream_pcnt: got %0d want 1", pc4); end
      total++;
      if (u4.u_rng.lfsr !== m4) begin bad++; $display("FAIL stream_lfsr: got %h want %h", u4.u_rng.lfsr, m4); end
      @(negedge clk);
      step4 = 1'b0; n4 = 16'h0104;
      @(posedge clk); #1;
      total++;
      if (st4 !== 4'b0001) begin bad++; $display("FAIL hold_state: got %b want 0001", st4); end
      total++;
      if (u4.u_rng.lfsr !== m4) begin bad++; $display("FAIL hold_lfsr: got %h want %h", u4.u_rng.lfsr, m4); end
      total++;
      if (rb4 !== m4[15]) begin bad++; $display("FAIL hold_rnd: got %b want %b", rb4, m4[15]); end
   endtask

   task automatic test_headon();
      @(negedge clk);
      n4 = 16'h0104; step4 = 1'b1; col4 = 1'b1;
      @(posedge clk); #1;
      m4 = lfsr_next(m4);
      total++;
      if (st4 !== 4'b1010) begin bad++; $display("FAIL headon_state: got %b want 1010", st4); end
      total++;
      if (cc4 !== 4'd1) begin bad++; $display("FAIL headon_cnt: got %0d want 1", cc4); end
      @(negedge clk);
      col4 = 1'b0;
      @(posedge clk); #1;
      m4 = lfsr_next(m4);
      total++;
      if (st4 !== 4'b0101) begin bad++; $display("FAIL free_state: got %b want 0101", st4); end
      total++;
      if (cc4 !== 4'd1) begin bad++; $display("FAIL free_cnt: got %0d want 1", cc4); end
      @(negedge clk);
      step4 = 1'b0;
   endtask

   task automatic test_wall();
      @(negedge clk);
      n4 = 16'h2100; wall4 = 1'b1; col4 = 1'b1; step4 = 1'b1;
      @(posedge clk); #1;
      m4 = lfsr_next(m4);
      total++;
      if (st4 !== 4'b1100) begin bad++; $display("FAIL wall4_state: got %b want 1100", st4); end
      total++;
      if (cc4 !== 4'd1) begin bad++; $display("FAIL wall4_cnt: got %0d want 1", cc4); end
      @(negedge clk);
      n6 = 36'h102040000; wall6 = 1'b1; col6 = 1'b1; step6 = 1'b1;
      step4 = 1'b0; wall4 = 1'b0;
      @(posedge clk); #1;
      m6 = lfsr_next(m6);
      total++;
      if (st6 !== 6'b111000) begin bad++; $display("FAIL wall6_state: got %b want 111000", st6); end
      total++;
      if (cc6 !== 8'd3 || pc6 !== 3'd3) begin bad++; $display("FAIL wall6_cnt: got %0d/%0d want 3/3", cc6, pc6); end
      @(negedge clk);
      step6 = 1'b0; wall6 = 1'b0;
   endtask

   task automatic test_fhp();
      total++;
      if (rb6 !== 1'b1) begin bad++; $display("FAIL fhp_seed_rnd: got %b want 1", rb6); end
      @(negedge clk);
      n6 = 36'h000040008; col6 = 1'b1; step6 = 1'b1;
      @(posedge clk); #1;
      m6 = lfsr_next(m6);
      total++;
      if (st6 !== 6'b010010) begin bad++; $display("FAIL fhp_pair_rnd1: got %b want 010010", st6); end
      total++;
      if (rb6 !== 1'b0) begin bad++; $display("FAIL fhp_rnd_next: got %b want 0", rb6); end
      @(posedge clk); #1;
      m6 = lfsr_next(m6);
      total++;
      if (st6 !== 6'b100100) begin bad++; $display("FAIL fhp_pair_rnd0: got %b want 100100", st6); end
      total++;
      if (cc6 !== 8'd2) begin bad++; $display("FAIL fhp_pair_cnt: got %0d want 2", cc6); end
      @(negedge clk);
      n6 = 36'h100040400;
      @(posedge clk); #1;
      m6 = lfsr_next(m6);
      total++;
      if (st6 !== 6'b101010) begin bad++; $display("FAIL fhp_triple: got %b want 101010", st6); end
      total++;
      if (cc6 !== 8'd3) begin bad++; $display("FAIL fhp_triple_cnt: got %0d want 3", cc6); end
      @(negedge clk);
      n6 = 36'h002040000;
      @(posedge clk); #1;
      m6 = lfsr_next(m6);
      total++;
      if (st6 !== 6'b000011) begin bad++; $display("FAIL fhp_plain: got %b want 000011", st6); end
      total++;
      if (cc6 !== 8'd3 || pc6 !== 3'd2) begin bad++; $display("FAIL fhp_plain_cnt: got %0d/%0d want 3/2", cc6, pc6); end
      total++;
      if (u6.u_rng.lfsr !== m6) begin bad++; $display("FAIL fhp_lfsr: got %h want %h", u6.u_rng.lfsr, m6); end
      @(negedge clk);
      step6 = 1'b0;
   endtask

   task automatic test_load_sat();
      logic [3:0] exp_cnt;
      @(negedge clk);
      load4 = 1'b1; step4 = 1'b1; ls4 = 4'b1111; n4 = 16'h0104; col4 = 1'b1;
      @(posedge clk); #1;
      total++;
      if (st4 !== 4'b1111) begin bad++; $display("FAIL load_state: got %b want 1111", st4); end
      total++;
      if (u4.u_rng.lfsr !== m4) begin bad++; $display("FAIL load_lfsr: got %h want %h", u4.u_rng.lfsr, m4); end
      total++;
      if (pc4 !== 3'd4 || cc4 !== 4'd1) begin bad++; $display("FAIL load_cnts: got %0d/%0d want 4/1", pc4, cc4); end
      @(negedge clk);
      load4 = 1'b0;
      exp_cnt = 4'd1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         m4 = lfsr_next(m4);
         if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
         total++;
         if (cc4 !== exp_cnt) begin bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cc4, exp_cnt); end
      end
      total++;
      if (cc4 !== 4'd15) begin bad++; $display("FAIL sat_final: got %0d want 15", cc4); end
      total++;
      if (st4 !== 4'b1010) begin bad++; $display("FAIL sat_state: got %b want 1010", st4); end
      total++;
      if (u4.u_rng.lfsr !== m4) begin bad++; $display("FAIL sat_lfsr: got %h want %h", u4.u_rng.lfsr, m4); end
      @(negedge clk);
      step4 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      n4 = '0; step4 = 1'b0; col4 = 1'b0; wall4 = 1'b0; load4 = 1'b0; ls4 = '0;
      n6 = '0; step6 = 1'b0; col6 = 1'b0; wall6 = 1'b0; load6 = 1'b0; ls6 = '0;
      m4 = 16'hACE1;
      m6 = 16'hACE1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_stream();
      test_headon();
      test_fhp();
      test_wall();
      test_load_sat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1);
   end

endmodule
